tdm_demux8: RTL and testbench

- Time-division demultiplexer, the receive-side inverse of the 8:1 mux path.
- Accepts one DW-bit sample per valid beat, steers it into slot 0..N_SLOTS-1 by an internal select counter, and presents the assembled frame with a valid/ready handshake.
- Sits at the receiving end of a serialized link whose transmitter drives d[s] for s = 0..7 in sequence.

---
 rtl/tdm_demux8.sv | 79 +++++++
 tb/tb_tdm_demux8.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - receive-side time-division demultiplexer, N_SLOTS samples per frame
// Samples fill slots by an internal counter; completed frames are held behind a valid/ready handshake.
module tdm_demux8 #(
  parameter  int N_SLOTS = 8,
  parameter  int DW      = 1,
  localparam int SEL_W   = $clog2(N_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic [N_SLOTS*DW-1:0] out_frame,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      slot,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  logic [SEL_W-1:0]      slot_q, slot_d;
  logic [N_SLOTS*DW-1:0] asm_q, asm_d;
  logic [N_SLOTS*DW-1:0] frame_q, frame_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic [SEL_W-1:0]      wr_idx;
  logic                  complete;

  always_comb begin
    wr_idx    = in_sof ? '0 : slot_q;
    asm_d     = asm_q;
    slot_d    = slot_q;
    frame_d   = frame_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    complete  = 1'b0;

    if (clr_overrun) overrun_d = 1'b0;
    if (valid_q && out_ready) valid_d = 1'b0;

    if (in_valid) begin
      asm_d[wr_idx*DW +: DW] = in_data;
      slot_d   = wr_idx + SEL_W'(1);
      complete = (wr_idx == SEL_W'(N_SLOTS-1));
    end

    // Holding slot free (or being freed this edge) takes the new frame; otherwise it is lost.
    if (complete) begin
      if (!valid_q || out_ready) begin
        frame_d = asm_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q    <= '0;
      asm_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      asm_q     <= asm_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_frame = frame_q;
  assign out_valid = valid_q;
  assign slot      = slot_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - scoreboard bench for tdm_demux8
// Driver feeds a frame-level reference model; a negedge monitor pops expected frames on acceptance.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] out_frame;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] slot;
  logic       overrun;
  logic       clr_overrun = 1'b0;

  int total = 0;
  int bad   = 0;

  tdm_demux8 dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .out_frame(out_frame), .out_valid(out_valid), .out_ready(out_ready),
    .slot(slot), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: position within frame, partial frame bits, holding-slot occupancy.
  int         m_pos = 0;
  bit   [7:0] m_part = 8'h00;
  bit         m_occ = 1'b0;
  bit         m_ovr = 1'b0;
  bit   [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         emitted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit done, drop;
    done = 1'b0;
    drop = 1'b0;
    if (!rst_n) begin
      m_pos = 0; m_part = 8'h00; m_occ = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
      return;
    end
    if (in_valid) begin
      if (in_sof) m_pos = 0;
      m_part[m_pos] = in_data[0];
      if (m_pos == 7) begin done = 1'b1; m_pos = 0; end
      else m_pos = m_pos + 1;
    end
    if (m_occ && out_ready) m_occ = 1'b0;
    if (done) begin
      if (m_occ) drop = 1'b1;
      else begin exp_q.push_back(m_part); m_occ = 1'b1; end
    end
    if (clr_overrun) m_ovr = 1'b0;
    if (drop) m_ovr = 1'b1;
  endtask

  task automatic cyc(input bit v, input bit sof, input bit d, input bit rdy, input bit clr);
    in_valid = v; in_sof = sof; in_data = d; out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_frame(input bit [7:0] f, input bit rdy, input int gap_max);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i == 0, f[i], rdy, 1'b0);
      if (gap_max > 0) begin
        int g = $urandom_range(gap_max, 1);
        for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("slot", slot, m_pos);
      chk("overrun", overrun, m_ovr);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (out_valid && exp_q.size() != 0) begin
        chk("out_frame", out_frame, exp_q[0]);
        if (out_ready && rst_n) begin
          void'(exp_q.pop_front());
          emitted++;
        end
      end
    end
  end

  initial begin
    int e0;
    // 1. reset with in_valid asserted
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_slot", slot, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_frame", out_frame, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // 2. single frame, consumer ready
    e0 = emitted;
    send_frame(8'hAA, 1'b1, 0);
    chk("t2_frame", out_frame, 8'hAA);
    chk("t2_valid", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid_drop", out_valid, 0);
    chk("t2_emitted", emitted - e0, 1);

    // 3. gapped input
    e0 = emitted;
    send_frame(8'hAA, 1'b1, 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_emitted", emitted - e0, 1);
    chk("t3_frame", out_frame, 8'hAA);

    // 4. backpressure and overrun
    send_frame(8'hAA, 1'b0, 0);
    send_frame(8'hF0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_frame_held", out_frame, 8'hAA);
    chk("t4_overrun", overrun, 1);
    chk("t4_valid", out_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_accepted", out_valid, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4_cleared", overrun, 0);

    // 5. resync on sof after partial frame
    e0 = emitted;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_partial_valid", out_valid, 0);
    send_frame(8'hF0, 1'b1, 0);
    chk("t5_frame", out_frame, 8'hF0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_emitted", emitted - e0, 1);

    // 6. reset mid-frame at slot 5
    for (int i = 0; i < 5; i++) cyc(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
    chk("t6_slot5", slot, 5);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    chk("t6_rst_slot", slot, 0);
    chk("t6_rst_valid", out_valid, 0);
    send_frame(8'hAA, 1'b1, 0);
    chk("t6_frame", out_frame, 8'hAA);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // random traffic: beats, rare sof, random backpressure and clears
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom_range(1, 0),
          $urandom_range(2, 0) != 0, $urandom_range(19, 0) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("final_drained", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
